// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stage stalls and clears,
// EX operand forwarding selects and saturating stall/flush counters.

module riscv_hazard_fwd (
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);
  // EX/MEM is the younger producer, so it wins over MEM/WB
  always_comb begin
    sel = 2'b00;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs)
      sel = 2'b10;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs)
      sel = 2'b01;
  end
endmodule

module riscv_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic             i_ex_redirect,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_regwrite,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_idex_stall,
  output logic             o_exmem_stall,
  output logic             o_memwb_stall,
  output logic             o_ifid_clr,
  output logic             o_idex_clr,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  localparam int NUM_OPS = 2;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_stall, load_use, flush_inc;

  logic [NUM_OPS-1:0][4:0] ex_rs;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign ex_rs = {i_ex_rs2, i_ex_rs1};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    riscv_hazard_fwd u_fwd (
      .ex_rs        (ex_rs[g]),
      .mem_rd       (i_mem_rd),
      .mem_regwrite (i_mem_regwrite),
      .wb_rd        (i_wb_rd),
      .wb_regwrite  (i_wb_regwrite),
      .sel          (fwd[g])
    );
  end

  assign o_fwd_a = i_rst ? 2'b00 : fwd[0];
  assign o_fwd_b = i_rst ? 2'b00 : fwd[1];

  assign mem_stall = i_dmem_req & ~i_dmem_ack;
  assign load_use  = i_ex_mem_read & (i_ex_rd != 5'd0) &
                     ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                      (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A memory wait freezes everything, including a pending redirect, which
  // is re-evaluated once the frozen EX instruction is released.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flush_inc     = 1'b0;
    o_pc_stall    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_idex_stall  = 1'b0;
    o_exmem_stall = 1'b0;
    o_memwb_stall = 1'b0;
    o_ifid_clr    = 1'b0;
    o_idex_clr    = 1'b0;
    if (!i_rst) begin
      if (mem_stall) begin
        o_pc_stall    = 1'b1;
        o_ifid_stall  = 1'b1;
        o_idex_stall  = 1'b1;
        o_exmem_stall = 1'b1;
        o_memwb_stall = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (i_ex_redirect) begin
              o_ifid_clr = 1'b1;
              o_idex_clr = 1'b1;
              flush_inc  = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state_nxt = REDIRECT;
                cnt_nxt   = 4'(FLUSH_CYCLES - 1);
              end
            end else if (load_use) begin
              o_pc_stall   = 1'b1;
              o_ifid_stall = 1'b1;
              o_idex_clr   = 1'b1;
            end
          end
          REDIRECT: begin
            // ID and EX hold wrong-path work here, so hazards are ignored
            o_ifid_clr = 1'b1;
            cnt_nxt    = cnt - 4'd1;
            if (cnt <= 4'd1) state_nxt = RUN;
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_pc_stall && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (flush_inc && o_flush_cnt != '1)  o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized traffic against a behavioural model.

module tb_riscv_hazard_ctrl;
  localparam int FC    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic i_clk = 1'b0;
  logic i_rst;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd, i_ex_rs1, i_ex_rs2, i_mem_rd, i_wb_rd;
  logic i_id_rs1_used, i_id_rs2_used, i_ex_mem_read, i_ex_redirect;
  logic i_mem_regwrite, i_wb_regwrite, i_dmem_req, i_dmem_ack;
  logic o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall, o_memwb_stall;
  logic o_ifid_clr, o_idex_clr;
  logic [1:0] o_fwd_a, o_fwd_b;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  riscv_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read),
    .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2), .i_ex_redirect(i_ex_redirect),
    .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite),
    .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
    .i_dmem_req(i_dmem_req), .i_dmem_ack(i_dmem_ack),
    .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall),
    .o_idex_stall(o_idex_stall), .o_exmem_stall(o_exmem_stall),
    .o_memwb_stall(o_memwb_stall), .o_ifid_clr(o_ifid_clr),
    .o_idex_clr(o_idex_clr), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       rs1u, rs2u;
    logic [4:0] ex_rd;
    logic       ex_mr;
    logic [4:0] ex_rs1, ex_rs2, mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       dreq, dack;
    logic [6:0] ectrl;   // {pc, ifid, idex, exmem, memwb stall, ifid clr, idex clr}
    logic [1:0] efa, efb;
  } vec_t;

  vec_t vecs [11];

  int nchk = 0, npass = 0;

  // model state: remaining IF/ID flush cycles after a redirect, counters
  int m_flush_left = 0, m_stall = 0, m_flush = 0;
  logic [6:0] e_ctrl;
  logic [1:0] e_fa, e_fb;

  function automatic logic [6:0] ctrl();
    return {o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall,
            o_memwb_stall, o_ifid_clr, o_idex_clr};
  endfunction

  function automatic logic [1:0] fwd_ref(logic [4:0] rs);
    if (i_mem_regwrite && i_mem_rd != 0 && i_mem_rd == rs) return 2'b10;
    if (i_wb_regwrite && i_wb_rd != 0 && i_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit lu, ms;
    ms = i_dmem_req && !i_dmem_ack;
    lu = i_ex_mem_read && i_ex_rd != 0 &&
         ((i_id_rs1_used && i_id_rs1 == i_ex_rd) || (i_id_rs2_used && i_id_rs2 == i_ex_rd));
    e_ctrl = 7'b0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (i_rst) begin
      m_flush_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (ms)                    e_ctrl = 7'b1111100;
      else if (m_flush_left > 0) e_ctrl = 7'b0000010;
      else if (i_ex_redirect)    e_ctrl = 7'b0000011;
      else if (lu)               e_ctrl = 7'b1100001;
      e_fa = fwd_ref(i_ex_rs1);
      e_fb = fwd_ref(i_ex_rs2);
    end
  endtask

  task automatic model_edge();
    if (i_rst) begin
      m_flush_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_ctrl[6] && m_stall < CMAX) m_stall++;
      if (!(i_dmem_req && !i_dmem_ack)) begin
        if (m_flush_left > 0) m_flush_left--;
        else if (i_ex_redirect) begin
          m_flush_left = FC - 1;
          if (m_flush < CMAX) m_flush++;
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // inputs are driven just after a rising edge; outputs are checked mid-cycle
  task automatic cyc(string nm, bit use_exp = 0, logic [6:0] ectrl = 7'b0);
    #2;
    model_eval();
    if (use_exp) chk({nm, "_ctrl_exp"}, 32'(ctrl()), 32'(ectrl));
    chk({nm, "_ctrl"}, 32'(ctrl()), 32'(e_ctrl));
    chk({nm, "_fwd"}, {28'd0, o_fwd_a, o_fwd_b}, {28'd0, e_fa, e_fb});
    chk({nm, "_cnt"}, {24'd0, o_stall_cnt, o_flush_cnt},
        {24'd0, 4'(m_stall), 4'(m_flush)});
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    i_id_rs1 = 0; i_id_rs2 = 0; i_id_rs1_used = 0; i_id_rs2_used = 0;
    i_ex_rd = 0; i_ex_mem_read = 0; i_ex_rs1 = 0; i_ex_rs2 = 0;
    i_ex_redirect = 0; i_mem_rd = 0; i_mem_regwrite = 0;
    i_wb_rd = 0; i_wb_regwrite = 0; i_dmem_req = 0; i_dmem_ack = 0;
  endtask

  task automatic load_use(logic [4:0] r);
    idle();
    i_ex_mem_read = 1; i_ex_rd = r; i_id_rs1 = r; i_id_rs1_used = 1; i_id_rs2 = 1;
  endtask

  task automatic do_reset();
    i_rst = 1; idle();
    cyc("reset");
    i_rst = 0;
  endtask

  initial begin
    vecs[0]  = '{0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 7'b0000000, 2'b00, 2'b00};
    vecs[1]  = '{5,1,1,1, 5,1, 0,0, 0,0, 0,0, 0,0, 7'b1100001, 2'b00, 2'b00};
    vecs[2]  = '{0,0,1,1, 0,1, 0,0, 0,0, 0,0, 0,0, 7'b0000000, 2'b00, 2'b00};
    vecs[3]  = '{1,5,1,0, 5,1, 0,0, 0,0, 0,0, 0,0, 7'b0000000, 2'b00, 2'b00};
    vecs[4]  = '{0,0,0,0, 0,0, 0,3, 0,1, 0,0, 0,0, 7'b0000000, 2'b00, 2'b00};
    vecs[5]  = '{0,0,0,0, 0,0, 7,0, 7,1, 7,1, 0,0, 7'b0000000, 2'b10, 2'b00};
    vecs[6]  = '{0,0,0,0, 0,0, 7,0, 7,0, 7,1, 0,0, 7'b0000000, 2'b01, 2'b00};
    vecs[7]  = '{0,0,0,0, 0,0, 0,9, 0,0, 9,1, 0,0, 7'b0000000, 2'b00, 2'b01};
    vecs[8]  = '{3,12,0,1, 12,1, 0,0, 0,0, 0,0, 0,0, 7'b1100001, 2'b00, 2'b00};
    vecs[9]  = '{5,0,1,0, 0,0, 0,0, 0,0, 0,0, 1,1, 7'b0000000, 2'b00, 2'b00};
    vecs[10] = '{5,0,1,0, 5,1, 4,4, 4,1, 0,0, 1,0, 7'b1111100, 2'b10, 2'b10};

    i_rst = 1; idle();
    #1;
    do_reset();
    chk("reset_stall_cnt", 32'(o_stall_cnt), 32'd0);

    // table vectors, all applied from RUN
    for (int i = 0; i < 11; i++) begin
      idle();
      i_id_rs1 = vecs[i].rs1; i_id_rs2 = vecs[i].rs2;
      i_id_rs1_used = vecs[i].rs1u; i_id_rs2_used = vecs[i].rs2u;
      i_ex_rd = vecs[i].ex_rd; i_ex_mem_read = vecs[i].ex_mr;
      i_ex_rs1 = vecs[i].ex_rs1; i_ex_rs2 = vecs[i].ex_rs2;
      i_mem_rd = vecs[i].mem_rd; i_mem_regwrite = vecs[i].mem_rw;
      i_wb_rd = vecs[i].wb_rd; i_wb_regwrite = vecs[i].wb_rw;
      i_dmem_req = vecs[i].dreq; i_dmem_ack = vecs[i].dack;
      #2;
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl()), 32'(vecs[i].ectrl));
      chk($sformatf("vec%0d_fwd", i), {28'd0, o_fwd_a, o_fwd_b},
          {28'd0, vecs[i].efa, vecs[i].efb});
      #(-2 + 2);
      cyc($sformatf("vec%0d", i));
    end

    // single load-use bubble
    do_reset();
    load_use(5);
    cyc("lu_T", 1, 7'b1100001);
    idle();
    cyc("lu_T1", 1, 7'b0000000);
    chk("lu_stall_cnt", 32'(o_stall_cnt), 32'd1);

    // redirect: clears at T and T+1, load-use at T+1 ignored, RUN at T+2
    do_reset();
    idle(); i_ex_redirect = 1;
    cyc("redir_T", 1, 7'b0000011);
    load_use(5); i_ex_redirect = 1;
    cyc("redir_T1", 1, 7'b0000010);
    chk("redir_flush_cnt", 32'(o_flush_cnt), 32'd1);
    load_use(5);
    cyc("redir_T2", 1, 7'b1100001);

    // memory wait holds off a redirect until ack
    do_reset();
    idle(); i_ex_redirect = 1; i_dmem_req = 1;
    for (int i = 0; i < 3; i++) cyc($sformatf("mwait%0d", i), 1, 7'b1111100);
    i_dmem_ack = 1;
    cyc("mwait_ack", 1, 7'b0000011);
    chk("mwait_stall_cnt", 32'(o_stall_cnt), 32'd3);
    idle();
    cyc("mwait_after", 1, 7'b0000010);
    chk("mwait_flush_cnt", 32'(o_flush_cnt), 32'd1);

    // reset in the middle of REDIRECT
    do_reset();
    idle(); i_ex_redirect = 1;
    cyc("rstmid_T", 1, 7'b0000011);
    load_use(6); i_dmem_req = 1; i_mem_regwrite = 1; i_mem_rd = 6; i_ex_rs1 = 6;
    i_rst = 1;
    cyc("rstmid_rst", 1, 7'b0000000);
    chk("rstmid_flush_cnt", 32'(o_flush_cnt), 32'd0);
    i_rst = 0; idle();
    cyc("rstmid_run", 1, 7'b0000000);

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      load_use(5'(1 + (i % 31)));
      cyc($sformatf("sat%0d", i));
    end
    idle();
    cyc("sat_end");
    chk("sat_stall_cnt", 32'(o_stall_cnt), 32'd15);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_id_rs1 = 5'($urandom_range(0, 3)); i_id_rs2 = 5'($urandom_range(0, 3));
      i_id_rs1_used = 1'($urandom_range(0, 1)); i_id_rs2_used = 1'($urandom_range(0, 1));
      i_ex_rd = 5'($urandom_range(0, 3)); i_ex_mem_read = 1'($urandom_range(0, 1));
      i_ex_rs1 = 5'($urandom_range(0, 3)); i_ex_rs2 = 5'($urandom_range(0, 3));
      i_ex_redirect = ($urandom_range(0, 5) == 0);
      i_mem_rd = 5'($urandom_range(0, 3)); i_mem_regwrite = 1'($urandom_range(0, 1));
      i_wb_rd = 5'($urandom_range(0, 3)); i_wb_regwrite = 1'($urandom_range(0, 1));
      i_dmem_req = ($urandom_range(0, 2) == 0); i_dmem_ack = 1'($urandom_range(0, 1));
      cyc($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/riscv_hazard_ctrl.md
# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It is the control source for the stage registers: it drives their stall and synchronous-clear inputs, including the ID/EX register's clear, which turns the ID/EX stage into a bubble. The block detects load-use hazards, data-memory wait states and taken branches/jumps, and generates the EX-stage operand forwarding selects. It also keeps two saturating performance counters.

## Interface
- FLUSH_CYCLES, 2: cycles IF/ID is cleared after a redirect (1..15); 2 covers the synchronous instruction memory's one-cycle fetch latency.
- CNT_W, 32: performance counter width.

- i_clk  in  1  core clock
- i_rst  in  1  asynchronous, active-high reset
- i_id_rs1 / i_id_rs2  in  5 each  source registers of the instruction in ID
- i_id_rs1_used / i_id_rs2_used  in  1 each  ID instruction actually reads rs1 / rs2
- i_ex_rd  in  5  destination register of the instruction in EX
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_rs1 / i_ex_rs2  in  5 each  source registers of the EX instruction
- i_ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
- i_mem_rd, i_mem_regwrite  in  5, 1  EX/MEM destination register and write enable
- i_wb_rd, i_wb_regwrite  in  5, 1  MEM/WB destination register and write enable
- i_dmem_req, i_dmem_ack  in  1, 1  data-memory access in MEM; access completes on ack
- o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall, o_memwb_stall  out  1 each  hold the PC / the named stage register
- o_ifid_clr, o_idex_clr  out  1 each  synchronous clear of IF/ID / ID/EX (ID/EX clear inserts a bubble)
- o_fwd_a, o_fwd_b  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- o_stall_cnt, o_flush_cnt  out  CNT_W each  performance counters

## Operation
- Internal conditions, all combinational:
  - mem_stall = i_dmem_req & ~i_dmem_ack.
  - load_use = i_ex_mem_read & (i_ex_rd != 0) & ((i_id_rs1_used & i_id_rs1 == i_ex_rd) | (i_id_rs2_used & i_id_rs2 == i_ex_rd)).
- Priority, highest first: mem_stall, then redirect, then load_use.
- mem_stall:
  - All five stall outputs are 1 and both clears are 0.
  - The FSM and the flush counter hold their values.
  - i_ex_redirect and load_use are ignored this cycle; the frozen EX instruction is re-evaluated once the stall ends.
- FSM state RUN:
  - If i_ex_redirect: o_ifid_clr=1 and o_idex_clr=1. Increment o_flush_cnt. If FLUSH_CYCLES>1, go to REDIRECT with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else if load_use: o_pc_stall=1, o_ifid_stall=1 and o_idex_clr=1, which inserts one bubble.
  - Otherwise: all control outputs are 0.
- FSM state REDIRECT:
  - o_ifid_clr=1 every cycle; all other controls are 0.
  - load_use and i_ex_redirect are ignored, because the EX and ID slots hold bubbles or wrong-path instructions.
  - cnt decrements each cycle; the FSM returns to RUN in the cycle after cnt reaches 1.
- Forwarding (combinational, independent of the FSM):
  - o_fwd_a = 10 if i_mem_regwrite & i_mem_rd != 0 & i_mem_rd == i_ex_rs1.
  - Else o_fwd_a = 01 if i_wb_regwrite & i_wb_rd != 0 & i_wb_rd == i_ex_rs1.
  - Else o_fwd_a = 00.
  - o_fwd_b uses the same rule with i_ex_rs2.
- Counters:
  - o_stall_cnt increments in every cycle where o_pc_stall=1.
  - o_flush_cnt increments once per accepted redirect.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (i_rst=1, asynchronous):
  - FSM goes to RUN, cnt=0, o_stall_cnt=0, o_flush_cnt=0.
  - All stall and clear outputs are 0, and o_fwd_a=o_fwd_b=00, for as long as i_rst is asserted, independent of the other inputs.
  - Reset in the middle of REDIRECT abandons the remaining flush cycles.
- Stall, clear and forward outputs are combinational in the same cycle as their inputs, with zero latency; stage registers sample them at the next i_clk edge.
- A load-use hazard produces exactly one bubble cycle. The next cycle the load sits in MEM and the dependent instruction receives o_fwd=01 via MEM/WB in the following cycle.
- A redirect in cycle T produces clears on IF/ID in cycles T..T+FLUSH_CYCLES-1 and on ID/EX in cycle T only.
- With mem_stall high for N cycles, o_stall_cnt rises by N.
- Counter updates are visible the cycle after the event.

## Test plan
- Load-use: EX holds `lw x5`, ID holds `add x6,x5,x1` with rs1_used=1 → for one cycle o_pc_stall=o_ifid_stall=o_idex_clr=1 and o_stall_cnt goes 0→1; the next cycle all controls are 0.
- x0 and unused operands: `lw x0` followed by a reader of x0, and `lw x5` followed by an instruction with rs2=5 but rs2_used=0 → no stall; in a separate cycle with i_mem_regwrite=1, i_mem_rd=0 and i_ex_rs1=0 → o_fwd_a=00.
- Forwarding priority: i_mem_rd=i_wb_rd=i_ex_rs1=7, both regwrite=1 → o_fwd_a=10; drop i_mem_regwrite → o_fwd_a=01.
- Redirect with FLUSH_CYCLES=2: i_ex_redirect pulses at T → o_ifid_clr=1 at T and T+1, o_idex_clr=1 only at T, a load_use presented at T+1 is ignored, o_flush_cnt=1, and the FSM is back in RUN at T+2.
- Memory wait: i_dmem_req=1 with ack low for 3 cycles while i_ex_redirect=1 → all stalls high for 3 cycles with no clears; on the ack cycle the redirect is accepted; o_stall_cnt=3 and o_flush_cnt=1.
- Reset and saturation: assert i_rst mid-REDIRECT → outputs 0 immediately and the FSM is in RUN after release; with CNT_W=4, drive 20 load-use stalls → o_stall_cnt holds at 15.
